mpmc11_ch_arbiter: RTL

//  Round-robin scheduler sharing the mpmc11 controller between NCH channel request FIFOs.

---
 rtl/mpmc11_ch_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mpmc11_ch_arbiter.sv
// mpmc11 channel arbiter: round-robin scheduler that pops one request from one of
// NCH channel FIFOs each time the controller FSM is in IDLE, then holds the grant
// until the controller has left IDLE and come back.
// Optional feature: define MPMC11_ARB_PRIO_EN to give channel 0 absolute priority.

package mpmc11_pkg;
    typedef enum logic [2:0] {
        IDLE,
        ACTIVATE,
        READ,
        WRITE,
        PRECHARGE,
        REFRESH
    } mpmc11_state_t;
endpackage

module mpmc11_ch_arbiter
    import mpmc11_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  mpmc11_state_t           state,
    input  logic                    calib_complete,
    input  logic [NCH-1:0]          empty,
    input  logic [NCH-1:0]          rd_rst_busy,
    input  logic [NCH-1:0]          ch_en,
    output logic [NCH-1:0]          rd,
    output logic [$clog2(NCH)-1:0]  ch_sel,
    output logic                    ch_vld,
    output logic                    err_timeout
);

    localparam int SW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_ACK,
        ARB_WAIT_DONE
    } arb_state_t;

    arb_state_t     arb_q, arb_d;
    logic [NCH-1:0] rd_d;
    logic [SW-1:0]  ch_sel_d;
    logic           ch_vld_d;
    logic           err_d;
    logic [SW-1:0]  last_q, last_d;
    logic [TW-1:0]  cnt_q, cnt_d;

    logic [NCH-1:0] elig;
    logic [SW-1:0]  rr_sel;
    logic           rr_found;
    logic [SW-1:0]  idx;
    logic [SW-1:0]  pick_sel;
    logic           pick_found;
    logic           pick_upd_last;

    assign elig = ch_en & ~empty & ~rd_rst_busy;

    // Round-robin search: first eligible channel after the last granted one, wrapping.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch;
        // blocking assignments are correct here because this is pure combinational logic.
        rr_found = 1'b0;
        rr_sel   = '0;
        idx      = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = SW'((int'(last_q) + k) % NCH);
            if (!rr_found && elig[idx]) begin
                rr_found = 1'b1;
                rr_sel   = idx;
            end
        end
    end

    // Final pick: optional channel-0 priority on top of the round-robin result.
    always_comb begin
        pick_sel      = rr_sel;
        pick_found    = rr_found;
        pick_upd_last = 1'b1;
`ifdef MPMC11_ARB_PRIO_EN
        // A ch0 priority win leaves the rotation pointer alone so the others keep their order.
        if (elig[0]) begin
            pick_sel      = '0;
            pick_found    = 1'b1;
            pick_upd_last = 1'b0;
        end
`endif
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        arb_d    = arb_q;
        rd_d     = '0;
        ch_sel_d = ch_sel;
        ch_vld_d = ch_vld;
        err_d    = 1'b0;
        last_d   = last_q;
        cnt_d    = cnt_q;
        if (!calib_complete) begin
            // Calibration loss aborts any grant but keeps the rotation position.
            arb_d    = ARB_IDLE;
            ch_vld_d = 1'b0;
        end else begin
            case (arb_q)
                ARB_IDLE: begin
                    if (state == IDLE && pick_found) begin
                        rd_d     = {{(NCH-1){1'b0}}, 1'b1} << pick_sel;
                        ch_sel_d = pick_sel;
                        ch_vld_d = 1'b1;
                        cnt_d    = '0;
                        arb_d    = ARB_WAIT_ACK;
                        if (pick_upd_last) begin
                            last_d = pick_sel;
                        end
                    end
                end
                ARB_WAIT_ACK: begin
                    if (state != IDLE) begin
                        arb_d = ARB_WAIT_DONE;
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        // Controller never picked up the popped entry.
                        err_d    = 1'b1;
                        ch_vld_d = 1'b0;
                        arb_d    = ARB_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ARB_WAIT_DONE: begin
                    // Returning to ARB_IDLE without granting forces a dead cycle.
                    if (state == IDLE) begin
                        ch_vld_d = 1'b0;
                        arb_d    = ARB_IDLE;
                    end
                end
                default: arb_d = ARB_IDLE;
            endcase
        end
    end

    // State register and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            arb_q       <= ARB_IDLE;
            rd          <= '0;
            ch_sel      <= '0;
            ch_vld      <= 1'b0;
            err_timeout <= 1'b0;
            last_q      <= SW'(NCH - 1);
            cnt_q       <= '0;
        end else begin
            arb_q       <= arb_d;
            rd          <= rd_d;
            ch_sel      <= ch_sel_d;
            ch_vld      <= ch_vld_d;
            err_timeout <= err_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
